// File: rtl/exhaustive_vector_driver_pkg.sv
// Shared definitions for the exhaustive vector driver: run states, default sizing
// and a MISR step function that checkers can use to recompute signatures.
package exhaustive_vector_driver_pkg;

  localparam int          N_IN_DEF     = 14;
  localparam int          SIG_W_DEF    = 16;
  localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
  localparam logic [15:0] SIG_SEED_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One MISR update for the default signature width.
  function automatic logic [SIG_W_DEF-1:0] misr_step(
    input logic [SIG_W_DEF-1:0] sig,
    input logic                 din,
    input logic [SIG_W_DEF-1:0] poly
  );
    logic fb;
    fb = sig[SIG_W_DEF-1] ^ din;
    return {sig[SIG_W_DEF-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/exhaustive_vector_driver_if.sv
// Vector (valid/ready) and response (valid only) links between the driver and the
// wrapper around the function under test.
interface exhaustive_vector_driver_if #(
  parameter int N_IN = 14
);
  logic            vec_valid;
  logic            vec_ready;
  logic [N_IN-1:0] vec;
  logic            resp_valid;
  logic            resp;

  modport master (
    output vec_valid,
    output vec,
    input  vec_ready,
    input  resp_valid,
    input  resp
  );

  modport slave (
    input  vec_valid,
    input  vec,
    output vec_ready,
    output resp_valid,
    output resp
  );
endinterface

// File: rtl/exhaustive_vector_driver_misr_accum.sv
// Serial-input MISR: shifts one response bit per enabled cycle into the signature.
module misr_accum #(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic             fb;

  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[SIG_W-1] ^ din_i;
    if (clear_i) begin
      sig_d = SIG_SEED;
    end else if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SIG_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/exhaustive_vector_driver.sv
// Enumerates every N_IN-bit vector over a valid/ready link, folds the in-order
// responses into a MISR and onset count, and compares against an expected signature.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing vectors, collecting responses
// DRAIN | all vectors issued, collecting outstanding responses
// DONE  | result valid; start re-runs
module exhaustive_vector_driver
  import exhaustive_vector_driver_pkg::*;
#(
  parameter int               N_IN     = N_IN_DEF,
  parameter int               SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEF[SIG_W-1:0],
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_SEED_DEF[SIG_W-1:0]
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [SIG_W-1:0]            exp_sig_i,
  exhaustive_vector_driver_if.master  vif,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic [SIG_W-1:0]            signature_o,
  output logic [N_IN:0]               onset_cnt_o
);

  localparam logic [N_IN:0] TOTAL = {1'b1, {N_IN{1'b0}}};

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN:0]    iss_cnt_q, iss_cnt_d;
  logic [N_IN:0]    recv_cnt_q, recv_cnt_d;
  logic [N_IN:0]    onset_cnt_q, onset_cnt_d;
  logic [SIG_W-1:0] exp_sig_q, exp_sig_d;
  logic             aborted_q, aborted_d;

  logic             vec_valid;
  logic             resp_take;
  logic             misr_clear;
  logic [SIG_W-1:0] signature;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    iss_cnt_d   = iss_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    onset_cnt_d = onset_cnt_q;
    exp_sig_d   = exp_sig_q;
    aborted_d   = aborted_q;
    vec_valid   = 1'b0;
    resp_take   = 1'b0;
    misr_clear  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // abort takes priority over a coincident start
        if (start_i && !abort_i) begin
          state_d     = ST_RUN;
          vec_d       = '0;
          iss_cnt_d   = '0;
          recv_cnt_d  = '0;
          onset_cnt_d = '0;
          exp_sig_d   = exp_sig_i;
          aborted_d   = 1'b0;
          misr_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        vec_valid = 1'b1;
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          resp_take = vif.resp_valid;
          if (vif.vec_ready) begin
            vec_d     = vec_q + 1'b1;
            iss_cnt_d = iss_cnt_q + 1'b1;
            if (iss_cnt_q == TOTAL - 1'b1) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          resp_take = vif.resp_valid;
          if (recv_cnt_q == TOTAL) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (resp_take) begin
      recv_cnt_d  = recv_cnt_q + 1'b1;
      onset_cnt_d = onset_cnt_q + {{N_IN{1'b0}}, vif.resp};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      iss_cnt_q   <= '0;
      recv_cnt_q  <= '0;
      onset_cnt_q <= '0;
      exp_sig_q   <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      iss_cnt_q   <= iss_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      onset_cnt_q <= onset_cnt_d;
      exp_sig_q   <= exp_sig_d;
      aborted_q   <= aborted_d;
    end
  end

  misr_accum #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(misr_clear),
    .en_i   (resp_take),
    .din_i  (vif.resp),
    .sig_o  (signature)
  );

  assign vif.vec_valid = vec_valid;
  assign vif.vec       = vec_q;

  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = (state_q == ST_DONE) && !aborted_q && (signature == exp_sig_q);
  assign signature_o = signature;
  assign onset_cnt_o = onset_cnt_q;

endmodule

// File: tb/tb_exhaustive_vector_driver.sv
// Directed bench for exhaustive_vector_driver with a latency-programmable response wrapper.
module tb_exhaustive_vector_driver;

  localparam int N  = 12;
  localparam int V  = 1 << N;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [SW-1:0] exp_sig_i = '0;
  logic          busy, done, pass;
  logic [SW-1:0] signature;
  logic [N:0]    onset_cnt;

  exhaustive_vector_driver_if #(.N_IN(N)) vif ();

  exhaustive_vector_driver #(
    .N_IN    (N),
    .SIG_W   (SW),
    .SIG_POLY(16'h1021),
    .SIG_SEED(16'h0000)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .exp_sig_i  (exp_sig_i),
    .vif        (vif),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .signature_o(signature),
    .onset_cnt_o(onset_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // response wrapper model
  typedef struct {
    logic r;
    int   due;
  } rsp_t;

  rsp_t         q[$];
  int           mode = 0;
  int           lat = 1;
  int           rdy_pct = 100;
  int           cyc = 0;
  int           hs_cnt = 0;
  int           stall_err = 0;
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_vec = '0;

  function automatic logic fn(input int m, input logic [N-1:0] v);
    case (m)
      0:       return 1'b0;
      1:       return v[0];
      2:       return 1'b1;
      default: return ^v[3:0];
    endcase
  endfunction

  function automatic logic [SW-1:0] model_sig(input int m, input int count);
    logic [SW-1:0] s;
    logic [N-1:0]  v;
    logic          fb;
    s = 16'h0000;
    for (int i = 0; i < count; i++) begin
      v  = N'(i);
      fb = s[SW-1] ^ fn(m, v);
      s  = {s[SW-2:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (prev_stall && vif.vec_valid && (vif.vec !== prev_vec)) stall_err++;
      if (rst_n && vif.vec_valid && vif.vec_ready && !abort_i) begin
        q.push_back('{r: fn(mode, vif.vec), due: cyc + lat - 1});
        hs_cnt++;
      end
      prev_stall = rst_n && vif.vec_valid && !vif.vec_ready;
      prev_vec   = vif.vec;
    end
  end

  initial begin
    vif.vec_ready  = 1'b0;
    vif.resp_valid = 1'b0;
    vif.resp       = 1'b0;
    forever begin
      @(negedge clk);
      vif.vec_ready = (int'($urandom_range(99)) < rdy_pct);
      if (q.size() > 0 && q[0].due <= cyc) begin
        vif.resp_valid = 1'b1;
        vif.resp       = q[0].r;
        void'(q.pop_front());
      end else begin
        vif.resp_valid = 1'b0;
        vif.resp       = 1'b0;
      end
    end
  end

  task automatic wait_queue_empty(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  typedef struct {
    int            mode;
    int            lat;
    int            rdy;
    logic [SW-1:0] flip;
    int            exp_onset;
    logic          exp_pass;
  } run_t;

  run_t tbl[5];

  initial begin
    int            n;
    logic [SW-1:0] sig_m;
    logic [SW-1:0] snap_sig;
    logic [N:0]    snap_on;

    tbl[0] = '{mode: 0, lat: 1, rdy: 100, flip: 16'h0000, exp_onset: 0,     exp_pass: 1'b1};
    tbl[1] = '{mode: 1, lat: 3, rdy: 100, flip: 16'h0000, exp_onset: V / 2, exp_pass: 1'b1};
    tbl[2] = '{mode: 2, lat: 2, rdy: 50,  flip: 16'h0000, exp_onset: V,     exp_pass: 1'b1};
    tbl[3] = '{mode: 1, lat: 3, rdy: 100, flip: 16'h0020, exp_onset: V / 2, exp_pass: 1'b0};
    tbl[4] = '{mode: 3, lat: 5, rdy: 75,  flip: 16'h0000, exp_onset: V / 2, exp_pass: 1'b1};

    #12;
    check("rst_vec_valid", vif.vec_valid, 0);
    check("rst_vec", vif.vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_signature", signature, 16'h0000);
    check("rst_onset", onset_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      wait_queue_empty($sformatf("run%0d_pre_drain", t));
      mode      = tbl[t].mode;
      lat       = tbl[t].lat;
      rdy_pct   = tbl[t].rdy;
      sig_m     = model_sig(tbl[t].mode, V);
      exp_sig_i = sig_m ^ tbl[t].flip;
      hs_cnt    = 0;
      stall_err = 0;
      pulse_start();
      check($sformatf("run%0d_busy", t), busy, 1);
      n = 0;
      while (!done && n < 8 * V) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("run%0d_done", t), done, 1);
      check($sformatf("run%0d_onset", t), onset_cnt, tbl[t].exp_onset);
      check($sformatf("run%0d_signature", t), signature, sig_m);
      check($sformatf("run%0d_pass", t), pass, tbl[t].exp_pass);
      check($sformatf("run%0d_handshakes", t), hs_cnt, V);
      check($sformatf("run%0d_stall_stable", t), stall_err, 0);
      check($sformatf("run%0d_idle_busy", t), busy, 0);
      check($sformatf("run%0d_vec_valid", t), vif.vec_valid, 0);
    end
    check("run0_zero_sig", model_sig(0, V), 16'h0000);
    check("ones_first_step", model_sig(2, 1), 16'h1021);

    // abort after 100 issues
    wait_queue_empty("abort_pre_drain");
    mode = 2; lat = 3; rdy_pct = 100; exp_sig_i = 16'h0000; hs_cnt = 0;
    pulse_start();
    n = 0;
    while (hs_cnt < 100 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_hs_reached", hs_cnt, 100);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_done", done, 1);
    check("abort_pass", pass, 0);
    check("abort_vec_valid", vif.vec_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_onset", onset_cnt, 97);
    check("abort_signature", signature, model_sig(2, 97));
    snap_sig = signature;
    snap_on  = onset_cnt;
    repeat (10) @(negedge clk);
    check("abort_frozen_onset", onset_cnt, snap_on);
    check("abort_frozen_sig", signature, snap_sig);
    check("abort_still_done", done, 1);

    // restart, then reset during DRAIN
    wait_queue_empty("restart_pre_drain");
    mode = 2; lat = 8; rdy_pct = 100;
    pulse_start();
    check("restart_vec", vif.vec, 0);
    check("restart_onset", onset_cnt, 0);
    check("restart_sig", signature, 16'h0000);
    check("restart_busy", busy, 1);
    check("restart_vec_valid", vif.vec_valid, 1);
    n = 0;
    while (!(busy && !vif.vec_valid) && n < 4 * V) begin
      @(negedge clk);
      n++;
    end
    check("drain_reached", busy && !vif.vec_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec_valid", vif.vec_valid, 0);
    check("mid_rst_vec", vif.vec, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_sig", signature, 16'h0000);
    check("mid_rst_onset", onset_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_stale_onset", onset_cnt, 0);
    check("post_rst_stale_sig", signature, 16'h0000);
    check("post_rst_busy", busy, 0);
    check("post_rst_queue", q.size(), 0);

    // start and abort together from IDLE: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
